// File: rtl/shifter_w_parallel_load_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// the default register width and the per-bit next-value selection.
package shifter_w_parallel_load_pkg;

    localparam int DEFAULT_BUSWIDTH = 8;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Pick the next value of one register bit from its four candidate sources.
    // Anything that is not a recognised mode (e.g. X in simulation) holds.
    function automatic logic select_next_bit(
        input logic [1:0] mode,
        input logic       hold_bit,
        input logic       shr_bit,
        input logic       shl_bit,
        input logic       load_bit
    );
        logic next_bit;
        next_bit = hold_bit;
        case (mode)
            MODE_HOLD: next_bit = hold_bit;
            MODE_SHR:  next_bit = shr_bit;
            MODE_SHL:  next_bit = shl_bit;
            MODE_LOAD: next_bit = load_bit;
            default:   next_bit = hold_bit;
        endcase
        return next_bit;
    endfunction

endpackage

// File: rtl/shifter_w_parallel_load_shift_mux_cell.sv
// One bit of the shift register: a 4:1 source mux in front of a flip-flop
// with synchronous, active-high reset.
module shift_mux_cell
    import shifter_w_parallel_load_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       hold_bit,
    input  logic       shr_bit,
    input  logic       shl_bit,
    input  logic       load_bit,
    output logic       q
);

    logic d;

    // Select the next bit value according to the shift/load mode.
    always_comb begin
        d = select_next_bit(mode, hold_bit, shr_bit, shl_bit, load_bit);
    end

    // Register the selected bit; reset wins over every mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/shifter_w_parallel_load.sv
// Universal shift register with parallel load. Each rising edge holds,
// shifts right (data_L fills the MSB), shifts left (data_R fills the LSB)
// or loads data_i. Shifted-out bits are dropped; there is no rotate.
// BUSWIDTH must be at least 2 so both end cells have a neighbour.
module shifter_w_parallel_load
    import shifter_w_parallel_load_pkg::*;
#(
    parameter int BUSWIDTH = DEFAULT_BUSWIDTH
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [BUSWIDTH-1:0] data_i,
    input  logic                data_L,
    input  logic                data_R,
    input  logic [1:0]          S_i,
    output logic [BUSWIDTH-1:0] Y_o
);

    logic [BUSWIDTH-1:0] q;

    // One mux/flop cell per bit; the end cells take their serial fill from
    // the external data_L/data_R pins instead of a neighbouring bit.
    genvar i;
    generate
        for (i = 0; i < BUSWIDTH; i++) begin : g_bit
            logic shr_src;
            logic shl_src;

            if (i == BUSWIDTH - 1) begin : g_msb
                assign shr_src = data_L;
            end else begin : g_mid_r
                assign shr_src = q[i+1];
            end

            if (i == 0) begin : g_lsb
                assign shl_src = data_R;
            end else begin : g_mid_l
                assign shl_src = q[i-1];
            end

            shift_mux_cell u_cell (
                .clk      (Clk),
                .rst      (Rst),
                .mode     (S_i),
                .hold_bit (q[i]),
                .shr_bit  (shr_src),
                .shl_bit  (shl_src),
                .load_bit (data_i[i]),
                .q        (q[i])
            );
        end
    endgenerate

    // Output is the register contents directly, no combinational path from inputs.
    always_comb begin
        Y_o = q;
    end

endmodule

// File: tb/tb_shifter_w_parallel_load.sv
module tb_shifter_w_parallel_load;

    logic       Clk;
    logic       Rst;
    logic [7:0] data_i;
    logic       data_L;
    logic       data_R;
    logic [1:0] S_i;
    logic [7:0] Y_o;

    int tests    = 0;
    int failures = 0;

    shifter_w_parallel_load #(.BUSWIDTH(8)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .data_i (data_i),
        .data_L (data_L),
        .data_R (data_R),
        .S_i    (S_i),
        .Y_o    (Y_o)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] expected);
        tests++;
        assert (Y_o === expected) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, Y_o, expected);
        end
    endtask

    logic [7:0] shl_tail [8];
    logic [7:0] fill_pat;

    initial begin
        shl_tail = '{8'h2B, 8'h57, 8'hAF, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
        fill_pat = 8'b0100_1101;

        // reset with load mode and all-ones data pending
        Rst = 1'b1; S_i = 2'b11; data_i = 8'hFF; data_L = 1'b1; data_R = 1'b1;
        tick();
        tick();
        check("reset", 8'h00);

        Rst = 1'b0; S_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_after_reset", 8'h00);
        end

        // load then hold, data_i changes must be ignored
        S_i = 2'b11; data_i = 8'hA5;
        tick();
        check("load_a5", 8'hA5);
        S_i = 2'b00; data_i = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_a5", 8'hA5);
        end

        // falling edge must not change anything
        S_i = 2'b11; data_i = 8'h00;
        @(negedge Clk);
        #1;
        check("negedge_no_effect", 8'hA5);
        S_i = 2'b00;

        // shift right with data_R toggling
        S_i = 2'b01; data_L = 1'b1; data_R = 1'b0; data_i = 8'hFF;
        tick();
        check("shr_1", 8'hD2);
        data_L = 1'b0; data_R = 1'b1;
        tick();
        check("shr_2", 8'h69);

        // reload and shift left
        S_i = 2'b11; data_i = 8'hA5;
        tick();
        check("reload_a5", 8'hA5);
        S_i = 2'b10; data_R = 1'b0; data_L = 1'b1; data_i = 8'h00;
        tick();
        check("shl_1", 8'h4A);
        data_R = 1'b1; data_L = 1'b0;
        tick();
        check("shl_2", 8'h95);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("shl_fill_%0d", k), shl_tail[k]);
        end

        // reset priority over a pending load
        S_i = 2'b11; data_i = 8'hA5;
        tick();
        check("prio_preload", 8'hA5);
        data_i = 8'h5A; Rst = 1'b1;
        tick();
        check("reset_priority", 8'h00);
        Rst = 1'b0;
        tick();
        check("load_after_reset", 8'h5A);

        // reset mid-shift, then full serial fill from the MSB end
        S_i = 2'b01; data_L = 1'b1;
        tick();
        check("shr_before_reset", 8'hAD);
        Rst = 1'b1;
        tick();
        check("reset_mid_shift", 8'h00);
        Rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            data_L = fill_pat[k];
            data_R = ~data_R;
            data_i = 8'hFF;
            tick();
        end
        check("serial_fill", 8'h4D);

        // hold ignores data_L/data_R
        S_i = 2'b00; data_L = 1'b1; data_R = 1'b1;
        tick();
        check("hold_after_fill", 8'h4D);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
